// File: rtl/rtds_tx_sched.sv
// rtds_tx_sched: ping-pong frame store that sends the active frame as one
// AXI-Stream packet a programmable delay after each transmit trigger.
`timescale 1ns/1ps
module rtds_tx_sched #(
  parameter int DATA_WIDTH  = 32,
  parameter int MAX_WORDS   = 64,
  parameter int ADDR_WIDTH  = 6,
  parameter int DELAY_WIDTH = 16
) (
  input  logic                   m_axis_aclk,
  input  logic                   m_axis_aresetn,
  input  logic                   wr_en,
  input  logic [ADDR_WIDTH-1:0]  wr_addr,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  input  logic                   wr_commit,
  input  logic [ADDR_WIDTH:0]    cfg_len,
  input  logic [DELAY_WIDTH-1:0] cfg_delay,
  input  logic                   trigger,
  output logic                   m_axis_tvalid,
  output logic [DATA_WIDTH-1:0]  m_axis_tdata,
  output logic                   m_axis_tlast,
  input  logic                   m_axis_tready,
  output logic                   busy,
  output logic                   commit_err,
  output logic [15:0]            drop_cnt,
  output logic [15:0]            pkt_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_SEND
  } state_e;

  localparam logic [ADDR_WIDTH:0] MAX_LEN = (ADDR_WIDTH + 1)'(MAX_WORDS);
  localparam logic [ADDR_WIDTH:0] LEN_ONE = (ADDR_WIDTH + 1)'(1);

  logic [DATA_WIDTH-1:0] bank0_mem [MAX_WORDS];
  logic [DATA_WIDTH-1:0] bank1_mem [MAX_WORDS];

  state_e                 state_q, state_d;
  logic                   bank_sel_q, bank_sel_d;
  logic [ADDR_WIDTH:0]    len_q, len_d;
  logic [ADDR_WIDTH:0]    pend_len_q, pend_len_d;
  logic                   pend_q, pend_d;
  logic                   frame_valid_q, frame_valid_d;
  logic [DELAY_WIDTH-1:0] dly_cnt_q, dly_cnt_d;
  logic [ADDR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
  logic                   commit_err_q, commit_err_d;
  logic [15:0]            drop_cnt_q, drop_cnt_d;
  logic [15:0]            pkt_cnt_q, pkt_cnt_d;

  logic                   commit_ok;
  logic                   swap_apply;
  logic                   drop;
  logic                   last_beat;
  logic [DATA_WIDTH-1:0]  rd_word;

  // Host writes always land in the bank that is not being transmitted.
  always_ff @(posedge m_axis_aclk) begin
    if (wr_en) begin
      if (bank_sel_q) begin
        bank0_mem[wr_addr] <= wr_data;
      end else begin
        bank1_mem[wr_addr] <= wr_data;
      end
    end
  end

  assign commit_ok  = (cfg_len != '0) && (cfg_len <= MAX_LEN);
  assign swap_apply = (state_q == ST_IDLE) && pend_q;
  assign last_beat  = ({1'b0, rd_ptr_q} == (len_q - LEN_ONE));
  assign rd_word    = bank_sel_q ? bank1_mem[rd_ptr_q] : bank0_mem[rd_ptr_q];

  always_comb begin
    state_d       = state_q;
    bank_sel_d    = bank_sel_q;
    len_d         = len_q;
    pend_len_d    = pend_len_q;
    pend_d        = pend_q;
    frame_valid_d = frame_valid_q;
    dly_cnt_d     = dly_cnt_q;
    rd_ptr_d      = rd_ptr_q;
    commit_err_d  = commit_err_q;
    drop_cnt_d    = drop_cnt_q;
    pkt_cnt_d     = pkt_cnt_q;
    drop          = 1'b0;

    if (swap_apply) begin
      bank_sel_d    = ~bank_sel_q;
      len_d         = pend_len_q;
      frame_valid_d = 1'b1;
      pend_d        = 1'b0;
    end

    if (wr_commit) begin
      if (commit_ok) begin
        pend_len_d = cfg_len;
        pend_d     = 1'b1;
      end else begin
        commit_err_d = 1'b1;
      end
    end

    // WAIT always lasts dly_cnt+1 cycles, so trigger-to-first-valid is delay+1.
    case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          if (frame_valid_q && !swap_apply) begin
            dly_cnt_d = cfg_delay;
            rd_ptr_d  = '0;
            state_d   = ST_WAIT;
          end else begin
            drop = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        drop = trigger;
        if (dly_cnt_q == '0) begin
          state_d = ST_SEND;
        end else begin
          dly_cnt_d = dly_cnt_q - DELAY_WIDTH'(1);
        end
      end
      ST_SEND: begin
        drop = trigger;
        if (m_axis_tready) begin
          if (last_beat) begin
            state_d   = ST_IDLE;
            pkt_cnt_d = pkt_cnt_q + 16'd1;
          end else begin
            rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge m_axis_aclk) begin
    if (!m_axis_aresetn) begin
      state_q       <= ST_IDLE;
      bank_sel_q    <= 1'b0;
      len_q         <= '0;
      pend_len_q    <= '0;
      pend_q        <= 1'b0;
      frame_valid_q <= 1'b0;
      dly_cnt_q     <= '0;
      rd_ptr_q      <= '0;
      commit_err_q  <= 1'b0;
      drop_cnt_q    <= '0;
      pkt_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      bank_sel_q    <= bank_sel_d;
      len_q         <= len_d;
      pend_len_q    <= pend_len_d;
      pend_q        <= pend_d;
      frame_valid_q <= frame_valid_d;
      dly_cnt_q     <= dly_cnt_d;
      rd_ptr_q      <= rd_ptr_d;
      commit_err_q  <= commit_err_d;
      drop_cnt_q    <= drop_cnt_d;
      pkt_cnt_q     <= pkt_cnt_d;
    end
  end

  // Data and last are forced low outside SEND so every output reads 0 after reset.
  assign m_axis_tvalid = (state_q == ST_SEND);
  assign m_axis_tdata  = m_axis_tvalid ? rd_word : '0;
  assign m_axis_tlast  = m_axis_tvalid && last_beat;
  assign busy          = (state_q != ST_IDLE);
  assign commit_err    = commit_err_q;
  assign drop_cnt      = drop_cnt_q;
  assign pkt_cnt       = pkt_cnt_q;

endmodule

// File: tb/tb_rtds_tx_sched.sv
// tb_rtds_tx_sched: directed self-checking bench for rtds_tx_sched.
`timescale 1ns/1ps
module tb_rtds_tx_sched;

  logic        m_axis_aclk;
  logic        m_axis_aresetn;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_commit;
  logic [6:0]  cfg_len;
  logic [15:0] cfg_delay;
  logic        trigger;
  logic        m_axis_tvalid;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tlast;
  logic        m_axis_tready;
  logic        busy;
  logic        commit_err;
  logic [15:0] drop_cnt;
  logic [15:0] pkt_cnt;

  int checks;
  int failures;

  rtds_tx_sched #(
    .DATA_WIDTH (32),
    .MAX_WORDS  (64),
    .ADDR_WIDTH (6),
    .DELAY_WIDTH(16)
  ) dut (
    .m_axis_aclk   (m_axis_aclk),
    .m_axis_aresetn(m_axis_aresetn),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_commit     (wr_commit),
    .cfg_len       (cfg_len),
    .cfg_delay     (cfg_delay),
    .trigger       (trigger),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .busy          (busy),
    .commit_err    (commit_err),
    .drop_cnt      (drop_cnt),
    .pkt_cnt       (pkt_cnt)
  );

  initial m_axis_aclk = 1'b0;
  always #5 m_axis_aclk = ~m_axis_aclk;

  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cyc();
    @(negedge m_axis_aclk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("[TB] comparison %s did not match", tag);
    end
  endtask

  task automatic write_word(input logic [5:0] addr, input logic [31:0] data);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_data = data;
    cyc();
    wr_en   = 1'b0;
  endtask

  task automatic commit(input logic [6:0] len);
    cfg_len   = len;
    wr_commit = 1'b1;
    cyc();
    wr_commit = 1'b0;
    cyc();
  endtask

  // mode 1 injects three triggers mid-packet; mode 2 writes and commits a new 3-word frame.
  task automatic run_packet(input string tag, input logic [31:0] base, input int exp_len,
                            input int mode);
    int beats;
    int data_bad;
    int last_bad;
    beats         = 0;
    data_bad      = 0;
    last_bad      = 0;
    m_axis_tready = 1'b1;
    cfg_delay     = 16'd0;
    trigger       = 1'b1;
    cyc();
    trigger = 1'b0;
    for (int i = 0; i < 70; i++) begin
      trigger   = (mode == 1) && (i == 5 || i == 20 || i == 40);
      wr_en     = (mode == 2) && (i >= 3) && (i <= 5);
      wr_addr   = 6'(i - 3);
      wr_data   = 32'(32'hB000 + i - 3);
      wr_commit = (mode == 2) && (i == 6);
      cfg_len   = 7'd3;
      if (m_axis_tvalid) begin
        if (m_axis_tdata !== 32'(base + beats)) data_bad++;
        if (m_axis_tlast !== (beats == exp_len - 1)) last_bad++;
        beats++;
      end
      cyc();
    end
    trigger   = 1'b0;
    wr_en     = 1'b0;
    wr_commit = 1'b0;
    check({tag, "_beats"}, beats, exp_len);
    check({tag, "_data"}, data_bad, 0);
    check({tag, "_tlast"}, last_bad, 0);
  endtask

  initial begin
    int          lat;
    int          hs;
    int          stall_bad;
    logic        prev_stalled;
    logic [31:0] prev_data;
    logic        prev_last;
    logic [31:0] beat_data [4];
    logic        beat_last [4];

    checks         = 0;
    failures       = 0;
    m_axis_aresetn = 1'b0;
    wr_en          = 1'b0;
    wr_addr        = '0;
    wr_data        = '0;
    wr_commit      = 1'b0;
    cfg_len        = '0;
    cfg_delay      = '0;
    trigger        = 1'b0;
    m_axis_tready  = 1'b0;
    cyc();
    cyc();
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_busy", busy, 0);
    check("rst_commit_err", commit_err, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_pkt_cnt", pkt_cnt, 0);
    m_axis_aresetn = 1'b1;
    cyc();

    $display("[TB] trigger with no committed frame");
    trigger = 1'b1;
    cyc();
    trigger = 1'b0;
    check("nofr_drop_cnt", drop_cnt, 1);
    check("nofr_busy", busy, 0);

    $display("[TB] two-word frame, zero delay");
    write_word(6'd0, 32'h5);
    write_word(6'd1, 32'h3);
    commit(7'd2);
    cfg_delay     = 16'd0;
    m_axis_tready = 1'b1;
    trigger       = 1'b1;
    cyc();
    trigger = 1'b0;
    check("t1_tvalid_early", m_axis_tvalid, 0);
    check("t1_busy_wait", busy, 1);
    cyc();
    check("t1_b0_tvalid", m_axis_tvalid, 1);
    check("t1_b0_tdata", m_axis_tdata, 32'h5);
    check("t1_b0_tlast", m_axis_tlast, 0);
    cyc();
    check("t1_b1_tdata", m_axis_tdata, 32'h3);
    check("t1_b1_tlast", m_axis_tlast, 1);
    cyc();
    check("t1_end_tvalid", m_axis_tvalid, 0);
    check("t1_pkt_cnt", pkt_cnt, 1);
    check("t1_busy_end", busy, 0);

    $display("[TB] delay 10 with toggling ready");
    cfg_delay     = 16'd10;
    m_axis_tready = 1'b1;
    trigger       = 1'b1;
    cyc();
    trigger = 1'b0;
    lat     = 0;
    while (!m_axis_tvalid && lat < 40) begin
      cyc();
      lat++;
    end
    check("t2_latency", lat, 11);
    hs           = 0;
    stall_bad    = 0;
    prev_stalled = 1'b0;
    prev_data    = '0;
    prev_last    = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (prev_stalled && (!m_axis_tvalid || m_axis_tdata !== prev_data ||
                           m_axis_tlast !== prev_last)) stall_bad++;
      m_axis_tready = ~m_axis_tready;
      if (m_axis_tvalid && m_axis_tready) begin
        if (hs < 4) begin
          beat_data[hs] = m_axis_tdata;
          beat_last[hs] = m_axis_tlast;
        end
        hs++;
      end
      prev_stalled = m_axis_tvalid && !m_axis_tready;
      prev_data    = m_axis_tdata;
      prev_last    = m_axis_tlast;
      cyc();
    end
    check("t2_handshakes", hs, 2);
    check("t2_stall_stable", stall_bad, 0);
    check("t2_b0_tdata", beat_data[0], 32'h5);
    check("t2_b0_tlast", beat_last[0], 0);
    check("t2_b1_tdata", beat_data[1], 32'h3);
    check("t2_b1_tlast", beat_last[1], 1);
    check("t2_pkt_cnt", pkt_cnt, 2);

    $display("[TB] 64-word frame with triggers during the packet");
    for (int i = 0; i < 64; i++) write_word(6'(i), 32'(32'hA000 + i));
    commit(7'd64);
    run_packet("t3", 32'hA000, 64, 1);
    check("t3_drop_cnt", drop_cnt, 4);
    check("t3_pkt_cnt", pkt_cnt, 3);

    $display("[TB] commit a new frame during a packet");
    run_packet("t4_old", 32'hA000, 64, 2);
    check("t4_old_pkt_cnt", pkt_cnt, 4);
    run_packet("t4_new", 32'hB000, 3, 0);
    check("t4_new_pkt_cnt", pkt_cnt, 5);

    $display("[TB] invalid commit lengths");
    check("t5_err_before", commit_err, 0);
    commit(7'd0);
    check("t5_err_len0", commit_err, 1);
    commit(7'd65);
    check("t5_err_len65", commit_err, 1);
    run_packet("t5", 32'hB000, 3, 0);
    check("t5_pkt_cnt", pkt_cnt, 6);
    check("t5_drop_cnt", drop_cnt, 4);

    $display("[TB] reset in the middle of a packet");
    for (int i = 0; i < 10; i++) write_word(6'(i), 32'(32'hC000 + i));
    commit(7'd10);
    m_axis_tready = 1'b1;
    cfg_delay     = 16'd0;
    trigger       = 1'b1;
    cyc();
    trigger = 1'b0;
    for (int i = 0; i < 6; i++) cyc();
    check("t6_mid_tdata", m_axis_tdata, 32'hC005);
    m_axis_aresetn = 1'b0;
    cyc();
    check("t6_rst_tvalid", m_axis_tvalid, 0);
    check("t6_rst_tlast", m_axis_tlast, 0);
    check("t6_rst_pkt_cnt", pkt_cnt, 0);
    check("t6_rst_drop_cnt", drop_cnt, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_commit_err", commit_err, 0);
    m_axis_aresetn = 1'b1;
    cyc();
    trigger = 1'b1;
    cyc();
    trigger = 1'b0;
    check("t6_drop_cnt", drop_cnt, 1);
    check("t6_busy", busy, 0);
    cyc();
    check("t6_tvalid", m_axis_tvalid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
